pc_sequencer: RTL

Parametrised PC unit for the multicycle CPU datapath. It absorbs the PC-source selection mux and adds the registered PC and EPC, plus branch-conditional writes. It also runs a small exception-entry/return state machine and detects illegal source selects. It sits between the ALU/ALUOut/jump/MDR paths and the instruction-address port of memory.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_src_mux.sv | 40 ++++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU PC path.
//   - exception cause codes carried on exc_code / exc_cause_q
//   - encoding of the exception entry/return state machine
//   - default datapath width
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Exception causes (code 3 is reserved but still vectors normally)
   localparam logic [1:0] EXC_OPCODE = 2'd0;
   localparam logic [1:0] EXC_OVF    = 2'd1;
   localparam logic [1:0] EXC_DIV0   = 2'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXC_SAVE = 2'd1,
      EXC_VEC  = 2'd2
   } pc_state_t;

endpackage : cpu_pkg

// File: rtl/pc_src_mux.sv
// -----------------------------------------------------------------------------
// pc_src_mux
// NUM_SRC-way, WIDTH-bit selector for the next PC value.
// Ports:
//   src_bus   in  NUM_SRC*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel       in  SEL_W          channel select
//   pc_next   out WIDTH          selected channel, zero when sel is out of range
//   illegal   out 1              sel >= NUM_SRC
// -----------------------------------------------------------------------------
module pc_src_mux #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 3
) (
   input  logic [NUM_SRC*WIDTH-1:0] src_bus,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         pc_next,
   output logic                     illegal
);

   logic [WIDTH-1:0] chan [NUM_SRC];

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign chan[gi] = src_bus[gi*WIDTH +: WIDTH];
   end

   // Compare against every legal index rather than indexing directly, so a
   // select wider than the channel count can never read past the array.
   always_comb begin
      pc_next = '0;
      illegal = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            pc_next = chan[k];
            illegal = 1'b0;
         end
      end
   end

endmodule : pc_src_mux

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter unit for the multicycle datapath: source selection, PC and
// EPC registers, branch-qualified writes and a short exception entry sequence
// (IDLE -> EXC_SAVE -> EXC_VEC -> IDLE).
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   src_bus              packed PC source channels
//   pc_source            channel select for normal writes
//   pc_write             unconditional PC write
//   pc_write_cond        PC write qualified by branch_taken
//   branch_taken         branch condition from the ALU
//   exc_req, exc_code    exception request and cause
//   eret                 return from exception (PC <= EPC)
//   pc_q, epc_q          program counter, exception PC
//   pc_next              combinational selected source (0 if select illegal)
//   in_exc               exception sequence in progress
//   sel_fault            one-cycle pulse after a write with an illegal select
//   exc_cause_q          cause of the last accepted exception
// -----------------------------------------------------------------------------
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int               WIDTH      = DEFAULT_WIDTH,
   parameter int               NUM_SRC    = 4,
   parameter int               SEL_W      = 3,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [WIDTH-1:0] EXC_BASE   = WIDTH'(32'h0000_00FC),
   parameter int unsigned      EXC_STRIDE = 1,
   parameter int unsigned      EPC_OFFSET = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_SRC*WIDTH-1:0] src_bus,
   input  logic [SEL_W-1:0]         pc_source,
   input  logic                     pc_write,
   input  logic                     pc_write_cond,
   input  logic                     branch_taken,
   input  logic                     exc_req,
   input  logic [1:0]               exc_code,
   input  logic                     eret,
   output logic [WIDTH-1:0]         pc_q,
   output logic [WIDTH-1:0]         epc_q,
   output logic [WIDTH-1:0]         pc_next,
   output logic                     in_exc,
   output logic                     sel_fault,
   output logic [1:0]               exc_cause_q
);

   localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(EXC_STRIDE);
   localparam logic [WIDTH-1:0] EPC_OFF_W = WIDTH'(EPC_OFFSET);

   pc_state_t        state_q, state_d;
   logic [WIDTH-1:0] pc_d, epc_d;
   logic [1:0]       exc_cause_d;
   logic             sel_fault_d;
   logic             sel_illegal;
   logic             do_write;
   logic [WIDTH-1:0] exc_vector;

   pc_src_mux #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_src_mux (
      .src_bus (src_bus),
      .sel     (pc_source),
      .pc_next (pc_next),
      .illegal (sel_illegal)
   );

   assign do_write   = pc_write | (pc_write_cond & branch_taken);
   // Product is truncated to WIDTH, so a large stride simply wraps.
   assign exc_vector = EXC_BASE + STRIDE_W * {{(WIDTH-2){1'b0}}, exc_cause_q};

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   // Requests arriving outside IDLE are dropped, not queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (exc_req) state_d = EXC_SAVE;
         EXC_SAVE: state_d = EXC_VEC;
         EXC_VEC:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      in_exc = (state_q != IDLE);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      pc_d        = pc_q;
      epc_d       = epc_q;
      exc_cause_d = exc_cause_q;
      sel_fault_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Priority: exception > eret > write. A write that loses to eret
            // never raises sel_fault.
            if (exc_req) begin
               exc_cause_d = exc_code;
            end else if (eret) begin
               pc_d = epc_q;
            end else if (do_write) begin
               if (sel_illegal) sel_fault_d = 1'b1;
               else             pc_d        = pc_next;
            end
         end
         // PC was already advanced when the exception was raised; the
         // subtraction wraps modulo 2**WIDTH.
         EXC_SAVE: epc_d = pc_q - EPC_OFF_W;
         EXC_VEC:  pc_d  = exc_vector;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q        <= RESET_PC;
         epc_q       <= '0;
         exc_cause_q <= '0;
         sel_fault   <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         exc_cause_q <= exc_cause_d;
         sel_fault   <= sel_fault_d;
      end
   end

endmodule : pc_sequencer
